// File: rtl/bft_pkg.sv
// Shared link-packet definitions for the BFT leaf port.
package bft_pkg;

    localparam int unsigned PKT_W     = 49;
    localparam int unsigned BODY_W    = PKT_W - 1;
    localparam int unsigned VALID_BIT = 48;
    localparam int unsigned ADDR_MSB  = 47;
    localparam int unsigned ADDR_LSB  = 43;
    localparam int unsigned PORT_MSB  = 42;
    localparam int unsigned PORT_LSB  = 39;
    localparam int unsigned TAG_MSB   = 38;
    localparam int unsigned TAG_LSB   = 32;
    localparam int unsigned DATA_MSB  = 31;
    localparam int unsigned DATA_LSB  = 0;

    localparam int unsigned ADDR_W = ADDR_MSB - ADDR_LSB + 1;
    localparam int unsigned PORT_W = PORT_MSB - PORT_LSB + 1;
    localparam int unsigned TAG_W  = TAG_MSB - TAG_LSB + 1;
    localparam int unsigned DATA_W = DATA_MSB - DATA_LSB + 1;

    // Packet contents below the valid bit
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PORT_W-1:0] port;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } pkt_body_t;

    // Full link word as seen on the wire
    typedef struct packed {
        logic      valid;
        pkt_body_t body;
    } pkt_t;

    // Build a valid link word from header fields and payload
    function automatic logic [PKT_W-1:0] pack_pkt(
        input logic [ADDR_W-1:0] addr,
        input logic [PORT_W-1:0] port,
        input logic [TAG_W-1:0]  tag,
        input logic [DATA_W-1:0] data
    );
        pkt_t p;
        p.valid     = 1'b1;
        p.body.addr = addr;
        p.body.port = port;
        p.body.tag  = tag;
        p.body.data = data;
        return p;
    endfunction

    // Split a stored packet body back into its fields
    function automatic pkt_body_t unpack_body(input logic [BODY_W-1:0] w);
        return pkt_body_t'(w);
    endfunction

endpackage

// File: rtl/bft_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; caller qualifies push, a full FIFO may push when popping.
module bft_rx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 48
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  logic [W-1:0]           data_i,
    input  logic                   pop_i,
    output logic                   valid_o,
    output logic [W-1:0]           data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic          pop_eff;

    // Pointer, occupancy and head-valid next state; popping an empty FIFO is ignored
    always_comb begin
        pop_eff  = pop_i && valid_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (pop_eff) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_i)  wr_ptr_d = wr_ptr_q + AW'(1);
        count_d = count_q + CW'(push_i) - CW'(pop_eff);
        valid_d = (count_d != '0);
    end

    // Control registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Storage; when full with a pop, the write lands in the slot being read out this edge
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = valid_q;
    assign count_o = count_q;

endmodule

// File: rtl/leaf_bft_port.sv
// BFT-side endpoint for one leaf slot: TX packet formatting, RX buffering with resend, ap_start.
module leaf_bft_port
    import bft_pkg::*;
#(
    parameter int unsigned RX_DEPTH = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    output logic [PKT_W-1:0]          din_leaf_bft2interface,
    input  logic [PKT_W-1:0]          dout_leaf_interface2bft,
    output logic                      resend,
    output logic                      ap_start,
    input  logic                      start_req,
    input  logic                      stop_req,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    input  logic [ADDR_W-1:0]         tx_addr,
    input  logic [PORT_W-1:0]         tx_port,
    input  logic [TAG_W-1:0]          tx_tag,
    input  logic [DATA_W-1:0]         tx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic [ADDR_W-1:0]         rx_addr,
    output logic [PORT_W-1:0]         rx_port,
    output logic [TAG_W-1:0]          rx_tag,
    output logic [DATA_W-1:0]         rx_data,
    output logic [$clog2(RX_DEPTH):0] rx_count,
    output logic [CNT_W-1:0]          rx_drop_cnt,
    output logic [CNT_W-1:0]          tx_pkt_cnt
);

    localparam int unsigned CW = $clog2(RX_DEPTH) + 1;

    logic [PKT_W-1:0]  din_q, din_d;
    logic              resend_q, resend_d;
    logic              ap_start_q, ap_start_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic              pop;
    logic              arrival;
    logic              accept;
    logic [BODY_W-1:0] head;
    pkt_body_t         head_f;

    // Next state for TX register, accept/resend decision, ap_start and counters
    always_comb begin
        din_d      = '0;
        tx_cnt_d   = tx_cnt_q;
        resend_d   = 1'b0;
        drop_cnt_d = drop_cnt_q;
        ap_start_d = ap_start_q;

        pop     = rx_ready && rx_valid;
        arrival = dout_leaf_interface2bft[VALID_BIT];
        // A pop on the same edge frees the slot before the arrival is judged
        accept  = arrival && ((rx_count < CW'(RX_DEPTH)) || pop);

        if (tx_valid) begin
            din_d = pack_pkt(tx_addr, tx_port, tx_tag, tx_data);
            if (tx_cnt_q != '1) tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end

        if (arrival && !accept) begin
            resend_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end

        if (stop_req)       ap_start_d = 1'b0;
        else if (start_req) ap_start_d = 1'b1;
    end

    // State registers; reset abandons any packet in flight on the link
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din_q      <= '0;
            resend_q   <= 1'b0;
            ap_start_q <= 1'b0;
            tx_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            din_q      <= din_d;
            resend_q   <= resend_d;
            ap_start_q <= ap_start_d;
            tx_cnt_q   <= tx_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Only the body is stored; every buffered word is valid by construction
    bft_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .W     (BODY_W)
    ) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (accept),
        .data_i  (dout_leaf_interface2bft[BODY_W-1:0]),
        .pop_i   (pop),
        .valid_o (rx_valid),
        .data_o  (head),
        .count_o (rx_count)
    );

    assign head_f = unpack_body(head);
    assign rx_addr = head_f.addr;
    assign rx_port = head_f.port;
    assign rx_tag  = head_f.tag;
    assign rx_data = head_f.data;

    assign din_leaf_bft2interface = din_q;
    assign resend                 = resend_q;
    assign ap_start               = ap_start_q;
    assign tx_ready               = 1'b1;
    assign tx_pkt_cnt             = tx_cnt_q;
    assign rx_drop_cnt            = drop_cnt_q;

endmodule

// File: tb/tb_leaf_bft_port.sv
// Self-checking bench for leaf_bft_port: queue-based reference model plus directed sequences.
module tb_leaf_bft_port;

    localparam int unsigned RX_DEPTH = 8;
    localparam int unsigned CNT_W    = 8;   // narrow counters so saturation is reachable quickly
    localparam int unsigned CW       = $clog2(RX_DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [48:0]       din_leaf_bft2interface;
    logic [48:0]       dout_leaf_interface2bft = '0;
    logic              resend;
    logic              ap_start;
    logic              start_req = 1'b0;
    logic              stop_req = 1'b0;
    logic              tx_valid = 1'b0;
    logic              tx_ready;
    logic [4:0]        tx_addr = '0;
    logic [3:0]        tx_port = '0;
    logic [6:0]        tx_tag = '0;
    logic [31:0]       tx_data = '0;
    logic              rx_valid;
    logic              rx_ready = 1'b0;
    logic [4:0]        rx_addr;
    logic [3:0]        rx_port;
    logic [6:0]        rx_tag;
    logic [31:0]       rx_data;
    logic [CW-1:0]     rx_count;
    logic [CNT_W-1:0]  rx_drop_cnt;
    logic [CNT_W-1:0]  tx_pkt_cnt;

    leaf_bft_port #(.RX_DEPTH(RX_DEPTH), .CNT_W(CNT_W)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .din_leaf_bft2interface  (din_leaf_bft2interface),
        .dout_leaf_interface2bft (dout_leaf_interface2bft),
        .resend                  (resend),
        .ap_start                (ap_start),
        .start_req               (start_req),
        .stop_req                (stop_req),
        .tx_valid                (tx_valid),
        .tx_ready                (tx_ready),
        .tx_addr                 (tx_addr),
        .tx_port                 (tx_port),
        .tx_tag                  (tx_tag),
        .tx_data                 (tx_data),
        .rx_valid                (rx_valid),
        .rx_ready                (rx_ready),
        .rx_addr                 (rx_addr),
        .rx_port                 (rx_port),
        .rx_tag                  (rx_tag),
        .rx_data                 (rx_data),
        .rx_count                (rx_count),
        .rx_drop_cnt             (rx_drop_cnt),
        .tx_pkt_cnt              (tx_pkt_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [48:0] m_q[$];
    logic [48:0] m_din;
    logic        m_resend;
    logic        m_ap;
    int          m_txc;
    int          m_drop;
    int          cnt_max = (1 << CNT_W) - 1;

    typedef struct {
        logic        tv;
        logic [4:0]  a;
        logic [3:0]  p;
        logic [6:0]  t;
        logic [31:0] d;
        logic [48:0] exp_din;
        logic [7:0]  exp_cnt;
    } tx_vec_t;

    tx_vec_t tx_tab[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("din", 64'(din_leaf_bft2interface), 64'(m_din));
        check("resend", 64'(resend), 64'(m_resend));
        check("ap_start", 64'(ap_start), 64'(m_ap));
        check("tx_ready", 64'(tx_ready), 64'd1);
        check("rx_valid", 64'(rx_valid), 64'(m_q.size() != 0));
        check("rx_count", 64'(rx_count), 64'(m_q.size()));
        check("tx_pkt_cnt", 64'(tx_pkt_cnt), 64'(m_txc));
        check("rx_drop_cnt", 64'(rx_drop_cnt), 64'(m_drop));
        if (m_q.size() != 0) begin
            check("rx_head", 64'({rx_addr, rx_port, rx_tag, rx_data}), 64'(m_q[0][47:0]));
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        m_q.delete();
        m_din = '0; m_resend = 1'b0; m_ap = 1'b0; m_txc = 0; m_drop = 0;
        compare_all();
        @(posedge clk); #1;
        tx_valid = 1'b0; dout_leaf_interface2bft = '0; rx_ready = 1'b0;
        start_req = 1'b0; stop_req = 1'b0;
        reset_n = 1'b1;
    endtask

    // One clock edge with the given inputs; model advanced by the packet/FIFO rules, then compared
    task automatic cycle(input logic tv, input logic [4:0] a, input logic [3:0] p,
                         input logic [6:0] t, input logic [31:0] d, input logic [48:0] rxw,
                         input logic rr, input logic st, input logic sp);
        logic pop_m, acc_m;
        tx_valid = tv; tx_addr = a; tx_port = p; tx_tag = t; tx_data = d;
        dout_leaf_interface2bft = rxw; rx_ready = rr; start_req = st; stop_req = sp;
        pop_m = rr && (m_q.size() > 0);
        acc_m = rxw[48] && ((m_q.size() < int'(RX_DEPTH)) || pop_m);
        @(posedge clk); #1;
        if (pop_m) m_q.delete(0);
        if (acc_m) m_q.push_back(rxw);
        m_resend = rxw[48] && !acc_m;
        if (m_resend && m_drop < cnt_max) m_drop++;
        m_din = tv ? {1'b1, a, p, t, d} : 49'd0;
        if (tv && m_txc < cnt_max) m_txc++;
        if (sp) m_ap = 1'b0;
        else if (st) m_ap = 1'b1;
        compare_all();
    endtask

    function automatic logic [48:0] rand_word(input logic v);
        logic [47:0] r;
        r = {16'($urandom()), 32'($urandom())};
        return {v, r};
    endfunction

    task automatic idle(input logic rr);
        cycle(1'b0, '0, '0, '0, '0, '0, rr, 1'b0, 1'b0);
    endtask

    task automatic rx_word(input logic [48:0] w, input logic rr);
        cycle(1'b0, '0, '0, '0, '0, w, rr, 1'b0, 1'b0);
    endtask

    initial begin
        logic [48:0] w;
        int sent;

        tx_tab[0] = '{1'b1, 5'h03, 4'h2, 7'h11, 32'hDEADBEEF, 49'h1_1911_DEADBEEF, 8'd1};
        tx_tab[1] = '{1'b1, 5'h1F, 4'hF, 7'h7F, 32'hFFFFFFFF, 49'h1_FFFF_FFFFFFFF, 8'd2};
        tx_tab[2] = '{1'b1, 5'h00, 4'h0, 7'h00, 32'h00000000, 49'h1_0000_00000000, 8'd3};
        tx_tab[3] = '{1'b0, 5'h1F, 4'hF, 7'h7F, 32'h12345678, 49'h0,               8'd3};
        tx_tab[4] = '{1'b1, 5'h10, 4'h8, 7'h40, 32'hA5A5A5A5, 49'h1_8440_A5A5A5A5, 8'd4};

        // Reset, then reset again in the middle of mixed traffic
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 5'($urandom()), 4'($urandom()), 7'($urandom()), $urandom(),
                  rand_word(1'b1), 1'b0, 1'b1, 1'b0);
        end
        do_reset();

        // TX table: back-to-back sends, an idle cycle, one more send
        for (int i = 0; i < 5; i++) begin
            cycle(tx_tab[i].tv, tx_tab[i].a, tx_tab[i].p, tx_tab[i].t, tx_tab[i].d,
                  '0, 1'b0, 1'b0, 1'b0);
            check("tab_din", 64'(din_leaf_bft2interface), 64'(tx_tab[i].exp_din));
            check("tab_txcnt", 64'(tx_pkt_cnt), 64'(tx_tab[i].exp_cnt));
        end

        // RX fill to full, ninth word rejected with a single resend pulse
        do_reset();
        for (int i = 0; i < 8; i++) rx_word(rand_word(1'b1), 1'b0);
        check("fill_count", 64'(rx_count), 64'd8);
        check("fill_resend", 64'(resend), 64'd0);
        rx_word(rand_word(1'b1), 1'b0);
        check("reject_resend", 64'(resend), 64'd1);
        check("reject_drop", 64'(rx_drop_cnt), 64'd1);
        check("reject_count", 64'(rx_count), 64'd8);
        idle(1'b0);
        check("resend_drop", 64'(resend), 64'd0);
        // Two back-to-back rejects give two consecutive resend cycles
        rx_word(rand_word(1'b1), 1'b0);
        check("rej2a_resend", 64'(resend), 64'd1);
        rx_word(rand_word(1'b1), 1'b0);
        check("rej2b_resend", 64'(resend), 64'd1);
        check("rej2_drop", 64'(rx_drop_cnt), 64'd3);
        // Invalid words are ignored
        rx_word(rand_word(1'b0), 1'b0);
        check("invalid_resend", 64'(resend), 64'd0);

        // Full with pop on the same edge: accepted, count unchanged
        rx_word(rand_word(1'b1), 1'b1);
        check("fullpop_count", 64'(rx_count), 64'd8);
        check("fullpop_resend", 64'(resend), 64'd0);
        check("fullpop_drop", 64'(rx_drop_cnt), 64'd3);
        for (int i = 0; i < 10; i++) idle(1'b1);
        check("drain_count", 64'(rx_count), 64'd0);
        check("drain_valid", 64'(rx_valid), 64'd0);
        // Pop on empty is ignored
        idle(1'b1);
        check("empty_pop", 64'(rx_count), 64'd0);

        // Order and wrap: 20 words, random consumer, never offered when it would overflow
        do_reset();
        sent = 0;
        for (int c = 0; c < 400 && sent < 20; c++) begin
            logic rr;
            rr = 1'($urandom());
            if (($urandom() % 3 != 0) && (m_q.size() < int'(RX_DEPTH) || (rr && m_q.size() > 0))) begin
                rx_word(rand_word(1'b1), rr);
                sent++;
            end else begin
                idle(rr);
            end
        end
        check("order_sent", 64'(sent), 64'd20);
        for (int i = 0; i < 12; i++) idle(1'b1);
        check("order_drop", 64'(rx_drop_cnt), 64'd0);
        check("order_empty", 64'(rx_count), 64'd0);

        // ap_start control
        do_reset();
        cycle(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        check("ap_set", 64'(ap_start), 64'd1);
        cycle(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
        check("ap_both", 64'(ap_start), 64'd0);
        cycle(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("ap_clear", 64'(ap_start), 64'd0);

        // Fully random traffic against the model
        do_reset();
        for (int i = 0; i < 500; i++) begin
            cycle(1'($urandom()), 5'($urandom()), 4'($urandom()), 7'($urandom()), $urandom(),
                  rand_word(1'($urandom())), 1'($urandom()),
                  ($urandom() % 8 == 0), ($urandom() % 8 == 0));
        end

        // Counter saturation: continuous sends and continuous rejects
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 5'($urandom()), 4'($urandom()), 7'($urandom()), $urandom(),
                  rand_word(1'b1), 1'b0, 1'b0, 1'b0);
        end
        check("sat_tx", 64'(tx_pkt_cnt), 64'hFF);
        check("sat_drop", 64'(rx_drop_cnt), 64'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
